// File: rtl/sa_c2n_fetch_if.sv
// Bundle between the annealing controller, the decision stage and the
// cell-to-node fetch stage: read request, swap commit and registered result.
interface sa_c2n_fetch_if #(
    parameter int TH_BITS   = 3,
    parameter int CELL_BITS = 2
);
    logic                 en_in;
    logic [TH_BITS-1:0]   idx_in;
    logic                 v_in;
    logic [CELL_BITS-1:0] ca_in;
    logic [CELL_BITS-1:0] cb_in;

    logic                 swap_en;
    logic [TH_BITS-1:0]   swap_idx;
    logic [CELL_BITS-1:0] swap_ca;
    logic [CELL_BITS-1:0] swap_cb;

    logic                 ready;
    logic                 en_out;
    logic [TH_BITS-1:0]   idx_out;
    logic                 v_out;
    logic [CELL_BITS-1:0] ca_out;
    logic [CELL_BITS-1:0] cb_out;
    logic [CELL_BITS-1:0] na_out;
    logic [CELL_BITS-1:0] nb_out;

    modport master (
        output en_in, idx_in, v_in, ca_in, cb_in,
        output swap_en, swap_idx, swap_ca, swap_cb,
        input  ready, en_out, idx_out, v_out, ca_out, cb_out, na_out, nb_out
    );

    modport slave (
        input  en_in, idx_in, v_in, ca_in, cb_in,
        input  swap_en, swap_idx, swap_ca, swap_cb,
        output ready, en_out, idx_out, v_out, ca_out, cb_out, na_out, nb_out
    );
endinterface

// File: rtl/sa_c2n_fetch.sv
// Per-thread cell-to-node lookup with owned placement storage and swap commit.
// Optional macro SA_C2N_FWD_EN: forward a same-cycle commit into the read result.
module sa_c2n_fetch #(
    parameter int N_THREADS = 6,
    parameter int TH_BITS   = 3,
    parameter int CELL_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    sa_c2n_fetch_if.slave   bus
);
    localparam int AW        = TH_BITS + CELL_BITS;
    localparam int DEPTH     = 2 ** AW;
    localparam int INIT_LAST = N_THREADS * (2 ** CELL_BITS) - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        init_addr_reg, init_addr_next;
    logic                 init_we;
    logic                 run;

    logic [DEPTH-1:0][CELL_BITS-1:0] mem;

    logic                 swap_we;
    logic [AW-1:0]        addr_sa, addr_sb;
    logic [CELL_BITS-1:0] node_sa, node_sb;
    logic [CELL_BITS-1:0] rd_na, rd_nb;

    logic                 en_out_reg;
    logic [TH_BITS-1:0]   idx_out_reg;
    logic                 v_out_reg;
    logic [CELL_BITS-1:0] ca_out_reg, cb_out_reg, na_out_reg, nb_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= INIT;
            init_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            init_addr_reg <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_addr_next = init_addr_reg;
        init_we        = 1'b0;
        case (state_reg)
            INIT: begin
                init_we = 1'b1;
                if (init_addr_reg == AW'(INIT_LAST))
                    state_next = RUN;
                else
                    init_addr_next = init_addr_reg + AW'(1);
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run = (state_reg == RUN);

    // Commits to thread slots beyond N_THREADS are dropped rather than wrapped.
    assign swap_we = run && bus.swap_en &&
                     ({1'b0, bus.swap_idx} < (TH_BITS + 1)'(N_THREADS));
    assign addr_sa = {bus.swap_idx, bus.swap_ca};
    assign addr_sb = {bus.swap_idx, bus.swap_cb};
    assign node_sa = mem[addr_sa];
    assign node_sb = mem[addr_sb];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [CELL_BITS-1:0] cell_reg;
            always_ff @(posedge clk) begin
                if (init_we && init_addr_reg == AW'(gi))
                    cell_reg <= CELL_BITS'(gi);
                else if (swap_we && addr_sa == AW'(gi))
                    cell_reg <= node_sb;
                else if (swap_we && addr_sb == AW'(gi))
                    cell_reg <= node_sa;
            end
            assign mem[gi] = cell_reg;
        end
    endgenerate

    always_comb begin
        rd_na = mem[{bus.idx_in, bus.ca_in}];
        rd_nb = mem[{bus.idx_in, bus.cb_in}];
`ifdef SA_C2N_FWD_EN
        // Each read port independently sees the post-swap view of its thread.
        if (swap_we && bus.swap_idx == bus.idx_in) begin
            if (bus.ca_in == bus.swap_ca)      rd_na = node_sb;
            else if (bus.ca_in == bus.swap_cb) rd_na = node_sa;
            if (bus.cb_in == bus.swap_ca)      rd_nb = node_sb;
            else if (bus.cb_in == bus.swap_cb) rd_nb = node_sa;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_reg  <= 1'b0;
            idx_out_reg <= '0;
            v_out_reg   <= 1'b0;
            ca_out_reg  <= '0;
            cb_out_reg  <= '0;
            na_out_reg  <= '0;
            nb_out_reg  <= '0;
        end else begin
            en_out_reg <= run && bus.en_in;
            if (run && bus.en_in) begin
                idx_out_reg <= bus.idx_in;
                v_out_reg   <= bus.v_in;
                ca_out_reg  <= bus.ca_in;
                cb_out_reg  <= bus.cb_in;
                na_out_reg  <= rd_na;
                nb_out_reg  <= rd_nb;
            end
        end
    end

    assign bus.ready   = run;
    assign bus.en_out  = en_out_reg;
    assign bus.idx_out = idx_out_reg;
    assign bus.v_out   = v_out_reg;
    assign bus.ca_out  = ca_out_reg;
    assign bus.cb_out  = cb_out_reg;
    assign bus.na_out  = na_out_reg;
    assign bus.nb_out  = nb_out_reg;
endmodule

// File: tb/tb_sa_c2n_fetch.sv
// Scoreboard bench for sa_c2n_fetch: placement model as a plain 2-D array,
// expected reads queued by the driver and popped by a negedge monitor.
module tb_sa_c2n_fetch;
    localparam int NT = 6;
    localparam int TB = 3;
    localparam int CB = 2;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_c2n_fetch_if #(.TH_BITS(TB), .CELL_BITS(CB)) bus ();

    sa_c2n_fetch #(.N_THREADS(NT), .TH_BITS(TB), .CELL_BITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int v;
        int ca;
        int cb;
        int na;
        int nb;
    } exp_t;

    exp_t expq[$];
    exp_t last_exp = '{0, 0, 0, 0, 0, 0};
    exp_t mon_e;
    int   pl[8][NC];
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One driven cycle: optional read and optional commit, model updated after.
    task automatic cyc(input bit en, input int t, input bit v, input int ca, input int cb,
                       input bit sw, input int st, input int sa, input int sb);
        int   post[8][NC];
        exp_t e;
        post = pl;
        if (sw && st < NT) begin
            post[st][sa] = pl[st][sb];
            post[st][sb] = pl[st][sa];
        end
        bus.en_in    = en;
        bus.idx_in   = TB'(t);
        bus.v_in     = v;
        bus.ca_in    = CB'(ca);
        bus.cb_in    = CB'(cb);
        bus.swap_en  = sw;
        bus.swap_idx = TB'(st);
        bus.swap_ca  = CB'(sa);
        bus.swap_cb  = CB'(sb);
        if (en) begin
            e.idx = t; e.v = v; e.ca = ca; e.cb = cb;
`ifdef SA_C2N_FWD_EN
            e.na = post[t][ca];
            e.nb = post[t][cb];
`else
            e.na = pl[t][ca];
            e.nb = pl[t][cb];
`endif
            expq.push_back(e);
        end
        pl = post;
        tick();
    endtask

    task automatic read(input int t, input bit v, input int ca, input int cb);
        cyc(1'b1, t, v, ca, cb, 1'b0, 0, 0, 0);
    endtask

    task automatic swap(input int st, input int sa, input int sb);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1, st, sa, sb);
    endtask

    task automatic dump_all;
        for (int t = 0; t < NT; t++) begin
            read(t, 1'b1, 0, 1);
            read(t, 1'b0, 2, 3);
        end
    endtask

    task automatic do_reset;
        int n;
        bus.en_in   = 1'b0;
        bus.swap_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        expq.delete();
        last_exp = '{0, 0, 0, 0, 0, 0};
        rst = 1'b0;
        check("rst_ready", int'(bus.ready), 0);
        check("rst_en_out", int'(bus.en_out), 0);
        check("rst_v_out", int'(bus.v_out), 0);
        check("rst_idx_out", int'(bus.idx_out), 0);
        check("rst_ca_out", int'(bus.ca_out), 0);
        check("rst_cb_out", int'(bus.cb_out), 0);
        check("rst_na_out", int'(bus.na_out), 0);
        check("rst_nb_out", int'(bus.nb_out), 0);
        for (int t = 0; t < 8; t++)
            for (int c = 0; c < NC; c++)
                pl[t][c] = c;
        n = 0;
        while (!bus.ready && n < 60) begin
            tick();
            n++;
        end
        check("init_cycles", n, 24);
    endtask

    always @(negedge clk) begin
        if (!bus.ready) begin
            check("init_en_out", int'(bus.en_out), 0);
        end else if (bus.en_out) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: en_out=1 with no expected read at %0t", $time);
            end else begin
                mon_e = expq.pop_front();
                check("idx_out", int'(bus.idx_out), mon_e.idx);
                check("v_out", int'(bus.v_out), mon_e.v);
                check("ca_out", int'(bus.ca_out), mon_e.ca);
                check("cb_out", int'(bus.cb_out), mon_e.cb);
                check("na_out", int'(bus.na_out), mon_e.na);
                check("nb_out", int'(bus.nb_out), mon_e.nb);
                last_exp = mon_e;
            end
        end else begin
            check("hold_idx", int'(bus.idx_out), last_exp.idx);
            check("hold_v", int'(bus.v_out), last_exp.v);
            check("hold_na", int'(bus.na_out), last_exp.na);
            check("hold_nb", int'(bus.nb_out), last_exp.nb);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_in = 1'b0; bus.idx_in = '0; bus.v_in = 1'b0;
        bus.ca_in = '0;   bus.cb_in = '0;
        bus.swap_en = 1'b0; bus.swap_idx = '0; bus.swap_ca = '0; bus.swap_cb = '0;

        do_reset();
        read(5, 1'b1, 2, 3);

        swap(1, 0, 3);
        read(1, 1'b1, 0, 3);
        read(2, 1'b1, 0, 3);

        swap(4, 2, 2);
        swap(6, 0, 1);
        dump_all();

        cyc(1'b1, 0, 1'b1, 1, 2, 1'b1, 0, 1, 2);
        read(0, 1'b1, 1, 2);

        for (int i = 0; i < 3; i++)
            cyc(1'b0, $urandom_range(0, 5), 1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, 0, 0, 0);

        read(3, 1'b1, 0, 1);
        read(3, 1'b0, 2, 3);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 3));

        swap(2, 1, 3);
        swap(5, 0, 2);
        do_reset();
        dump_all();

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        check("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
